// File: rtl/store_write_buffer_if.sv
// Bus bundle for store_write_buffer: store port, load-check port and memory write port.
// slave is the buffer side; master is the execute stage / memory side.
interface store_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic          st_ready;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;

    logic [AW-1:0] ld_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] ld_data;
    logic          ld_hit;
    logic          ld_stall;

    logic          drain_hold;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wen;

    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, ld_addr, mem_rdata, drain_hold,
        input  st_ready, ld_data, ld_hit, ld_stall, mem_waddr, mem_wdata,
               mem_wen, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_addr, mem_rdata, drain_hold,
        output st_ready, ld_data, ld_hit, ld_stall, mem_waddr, mem_wdata,
               mem_wen, empty, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// FIFO of pending CPU stores ahead of the memory write port, with a load-address check.
// Define STORE_FORWARD_EN to forward matching store data; otherwise matching loads stall.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    store_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Entry payload is not reset; the per-entry valid bits and count gate its use.
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count_q;

    logic enq;
    logic deq;
    logic full;
    logic is_empty;
    logic match;

    assign full     = (count_q == FULL_COUNT);
    assign is_empty = (count_q == '0);
    // No pass-through when full: st_ready depends on state only.
    assign enq      = bus.st_valid && !full;
    assign deq      = !is_empty && !bus.drain_hold;

    assign bus.st_ready  = !full;
    assign bus.empty     = is_empty;
    assign bus.count     = count_q;
    assign bus.mem_wen   = deq;
    assign bus.mem_waddr = addr_mem[head];
    assign bus.mem_wdata = data_mem[head];

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_mem[tail] <= bus.st_addr;
            data_mem[tail] <= bus.st_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
            valid   <= '0;
        end else begin
            if (deq) begin
                head        <= head + PW'(1);
                valid[head] <= 1'b0;
            end
            // enq and deq never target the same slot: that needs count 0 or DEPTH.
            if (enq) begin
                tail        <= tail + PW'(1);
                valid[tail] <= 1'b1;
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef STORE_FORWARD_EN
    logic [DW-1:0] fwd_data;

    // Scan oldest to youngest so the youngest match overwrites earlier ones.
    always_comb begin
        match    = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[head + PW'(k)] && (addr_mem[head + PW'(k)] == bus.ld_addr)) begin
                match    = 1'b1;
                fwd_data = data_mem[head + PW'(k)];
            end
        end
    end

    assign bus.ld_hit   = match;
    assign bus.ld_stall = 1'b0;
    assign bus.ld_data  = match ? fwd_data : bus.mem_rdata;
`else
    always_comb begin
        match = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (valid[k] && (addr_mem[k] == bus.ld_addr)) begin
                match = 1'b1;
            end
        end
    end

    assign bus.ld_hit   = 1'b0;
    assign bus.ld_stall = match;
    assign bus.ld_data  = bus.mem_rdata;
`endif

endmodule
